// File: rtl/unaligned_write_splitter.sv
// ----------------------------------------------------------------------------
// unaligned_write_splitter
//
// Front-end for the word-aligned RAM write port. It accepts byte-addressed
// 32-bit writes at any alignment. Each write leaves as a word-aligned beat with
// byte strobes. A misaligned write becomes two beats: the low word first, then
// the high word. An aligned write passes through as a single beat. There is one
// register stage, and both sides use a valid/ready handshake.
//
// Build option:
//   STRICT_ALIGN_EN  when defined, misaligned writes are accepted and dropped.
//                    No beat is produced. err pulses for one cycle, and
//                    split_cnt counts these rejected writes.
//
// Ports:
//   clk, rst_n        clock (rising edge); asynchronous active-low reset
//   in_valid/ready    upstream handshake
//   in_addr           byte address, any alignment
//   in_wdata          write data, little-endian
//   out_valid/ready   downstream handshake
//   out_addr          word-aligned address ([1:0] == 0)
//   out_wdata         lane-positioned data; lanes without a strobe carry 0
//   out_strb          byte strobes, bit i enables lane [8i+7:8i]
//   out_last          final beat of the current request
//   err               one-cycle pulse on a rejected request (strict build only)
//   split_cnt         saturating count of split (or rejected) requests
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no beat held
// FIRST | beat 0 of a split held, beat 1 pending
// LAST  | single beat or final beat of a split held
// ----------------------------------------------------------------------------
module unaligned_write_splitter #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_wdata,
  output logic [3:0]        out_strb,
  output logic              out_last,
  output logic              err,
  output logic [CNT_W-1:0]  split_cnt
);

`ifdef STRICT_ALIGN_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_LAST  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            w_load_state;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_strb;
  logic              r_last;
  logic [31:0]       r_hi;
  logic [1:0]        r_off;
  logic [CNT_W-1:0]  r_split_cnt;

  logic [1:0]        w_off;
  logic              w_misaligned;
  logic              w_accept;
  logic              w_load_beat;
  logic              w_adv_beat1;
  logic [ADDR_W-1:0] w_base;
  logic [3:0]        w_strb0;
  logic [31:0]       w_data0;
  logic [5:0]        w_hi_shamt;
  logic [31:0]       w_hi;

  assign w_off        = in_addr[1:0];
  assign w_misaligned = |w_off;
  assign w_base       = {in_addr[ADDR_W-1:2], 2'b00};
  // When off is 0, these reduce to the full-word pass-through case.
  assign w_strb0      = 4'b1111 << w_off;
  assign w_data0      = in_wdata << {w_off, 3'b000};
  // Bytes that spill past the word boundary, shifted down to lane 0.
  assign w_hi_shamt   = 6'd32 - {1'b0, w_off, 3'b000};
  assign w_hi         = in_wdata >> w_hi_shamt;

  assign w_accept     = in_valid && in_ready;
  // In a strict build, a misaligned write is accepted but never loaded.
  assign w_load_beat  = w_accept && !(STRICT && w_misaligned);
  assign w_adv_beat1  = (r_state == S_FIRST) && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_load_state = S_LAST;
    if (w_misaligned) w_load_state = STRICT ? S_IDLE : S_FIRST;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = w_load_state;
      S_FIRST: if (out_ready) w_state_nxt = S_LAST;
      S_LAST:  if (out_ready) w_state_nxt = in_valid ? w_load_state : S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (r_state != S_IDLE);
    in_ready  = (r_state == S_IDLE) || ((r_state == S_LAST) && out_ready);
  end

  // Beat datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_last  <= 1'b0;
      r_hi    <= '0;
      r_off   <= '0;
    end else if (w_load_beat) begin
      r_addr  <= w_base;
      r_wdata <= w_data0;
      r_strb  <= w_strb0;
      r_last  <= !w_misaligned;
      r_hi    <= w_hi;
      r_off   <= w_off;
    end else if (w_adv_beat1) begin
      r_addr  <= r_addr + ADDR_W'(4);
      r_wdata <= r_hi;
      r_strb  <= 4'b1111 >> (3'd4 - {1'b0, r_off});
      r_last  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_split_cnt <= '0;
    else if (w_accept && w_misaligned && (r_split_cnt != '1))
      r_split_cnt <= r_split_cnt + CNT_W'(1);
  end

`ifdef STRICT_ALIGN_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_accept && w_misaligned;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign out_addr  = r_addr;
  assign out_wdata = r_wdata;
  assign out_strb  = r_strb;
  assign out_last  = r_last;
  assign split_cnt = r_split_cnt;

endmodule
